// File: rtl/see_pkg.sv
// Shared types and default sizes for the SEE fault-campaign controller.
package see_pkg;

   localparam int SEE_IN_W       = 9;
   localparam int SEE_OUT_W      = 5;
   localparam int SEE_NUM_FAULTS = 49;
   localparam int SEE_FAULT_W    = 6;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      REPORT,
      NEXT,
      FIN
   } see_state_t;

   typedef struct packed {
      logic [SEE_IN_W-1:0]    vec;
      logic [SEE_FAULT_W-1:0] fault;
      logic [SEE_OUT_W-1:0]   mask;
   } see_rec_t;

endpackage

// File: rtl/see_settle_timer.sv
// Loadable down-counter that stops at zero; zero flag tells the FSM the netlist has settled.
module see_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/see_campaign_ctrl.sv
// Exhaustive SEE campaign driver: walks every (fault, vector) pair, compares the golden and
// faulty netlist copies after a settle delay and emits one record per mismatching pair.
module see_campaign_ctrl
   import see_pkg::*;
#(
   parameter int IN_W       = SEE_IN_W,
   parameter int OUT_W      = SEE_OUT_W,
   parameter int NUM_FAULTS = SEE_NUM_FAULTS,
   parameter int FAULT_W    = SEE_FAULT_W,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [IN_W-1:0]    stim,
   output logic               fault_en,
   output logic [FAULT_W-1:0] fault_idx,
   input  logic [OUT_W-1:0]   gold_q,
   input  logic [OUT_W-1:0]   fault_q,
   output logic               rec_valid,
   input  logic               rec_ready,
   output logic [IN_W-1:0]    rec_vec,
   output logic [FAULT_W-1:0] rec_fault,
   output logic [OUT_W-1:0]   rec_mask,
   output logic [CNT_W-1:0]   err_cnt,
   output logic               busy,
   output logic               done
);

   localparam logic [FAULT_W-1:0] LAST_FAULT  = FAULT_W'(NUM_FAULTS - 1);
   localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   typedef struct packed {
      logic [IN_W-1:0]    vec;
      logic [FAULT_W-1:0] fault;
      logic [OUT_W-1:0]   mask;
   } rec_t;

   see_state_t         state_reg;
   logic [IN_W-1:0]    vec_reg;
   logic [FAULT_W-1:0] fault_reg;
   logic [IN_W-1:0]    stim_reg;
   logic [FAULT_W-1:0] fault_idx_reg;
   logic               fault_en_reg;
   rec_t               rec_reg;
   logic               rec_valid_reg;
   logic [CNT_W-1:0]   err_cnt_reg;
   logic               busy_reg;
   logic               done_reg;
   logic [OUT_W-1:0]   mask;
   logic               settle_zero;

   assign mask = gold_q ^ fault_q;

   see_settle_timer #(.W(4)) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (state_reg == APPLY),
      .load_val (SETTLE_LOAD),
      .dec      (state_reg == SETTLE),
      .zero     (settle_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         vec_reg       <= '0;
         fault_reg     <= '0;
         stim_reg      <= '0;
         fault_idx_reg <= '0;
         fault_en_reg  <= 1'b0;
         rec_reg       <= '0;
         rec_valid_reg <= 1'b0;
         err_cnt_reg   <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  err_cnt_reg <= '0;
                  vec_reg     <= '0;
                  fault_reg   <= '0;
                  busy_reg    <= 1'b1;
                  state_reg   <= APPLY;
               end
            end
            APPLY: begin
               stim_reg      <= vec_reg;
               fault_idx_reg <= fault_reg;
               fault_en_reg  <= 1'b1;
               state_reg     <= SETTLE;
            end
            SETTLE: begin
               if (settle_zero) begin
                  state_reg <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (mask != '0) begin
                  // Counter sticks at all-ones but records keep flowing.
                  if (err_cnt_reg != '1) begin
                     err_cnt_reg <= err_cnt_reg + CNT_W'(1);
                  end
                  rec_reg       <= '{vec: stim_reg, fault: fault_idx_reg, mask: mask};
                  rec_valid_reg <= 1'b1;
                  state_reg     <= REPORT;
               end else begin
                  state_reg <= NEXT;
               end
            end
            REPORT: begin
               if (rec_ready) begin
                  rec_valid_reg <= 1'b0;
                  state_reg     <= NEXT;
               end
            end
            NEXT: begin
               if (vec_reg == '1) begin
                  vec_reg <= '0;
                  if (fault_reg == LAST_FAULT) begin
                     state_reg <= FIN;
                  end else begin
                     fault_reg <= fault_reg + FAULT_W'(1);
                     state_reg <= APPLY;
                  end
               end else begin
                  vec_reg   <= vec_reg + IN_W'(1);
                  state_reg <= APPLY;
               end
            end
            FIN: begin
               fault_en_reg <= 1'b0;
               stim_reg     <= '0;
               busy_reg     <= 1'b0;
               done_reg     <= 1'b1;
               state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign stim      = stim_reg;
   assign fault_en  = fault_en_reg;
   assign fault_idx = fault_idx_reg;
   assign rec_valid = rec_valid_reg;
   assign rec_vec   = rec_reg.vec;
   assign rec_fault = rec_reg.fault;
   assign rec_mask  = rec_reg.mask;
   assign err_cnt   = err_cnt_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule
